// File: rtl/pipeline_arbiter.sv
// Round-robin arbiter feeding NREQ valid/ready producers into one registered output slot.
// The output slot carries a source tag so results can be routed back to the producer.
module pipeline_arbiter #(
   parameter  int unsigned NREQ  = 4,
   parameter  int unsigned WIDTH = 5,
   localparam int unsigned TAGW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       prev_valid,
   output logic [NREQ-1:0]       this_ready,
   input  logic [NREQ*WIDTH-1:0] input_num,
   output logic                  this_valid,
   input  logic                  next_ready,
   output logic [WIDTH-1:0]      output_num,
   output logic [TAGW-1:0]       output_tag
);

   logic [TAGW-1:0] ptr;
   logic [TAGW-1:0] winner;
   logic [TAGW-1:0] ptr_next;
   logic            found;
   logic            can_accept;
   logic            take;

   // First requester at or after ptr, wrapping past NREQ-1.
   always_comb begin
      logic [TAGW-1:0] idx;
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = TAGW'((32'(ptr) + k) % NREQ);
         if (!found && prev_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign can_accept = !this_valid || next_ready;
   assign take       = reset && can_accept && found;
   assign this_ready = take ? (NREQ'(1) << winner) : '0;
   assign ptr_next   = (32'(winner) == NREQ - 1) ? '0 : winner + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         this_valid <= 1'b0;
         output_num <= '0;
         output_tag <= '0;
         ptr        <= '0;
      end else if (take) begin
         this_valid <= 1'b1;
         output_num <= input_num[32'(winner)*WIDTH +: WIDTH];
         output_tag <= winner;
         ptr        <= ptr_next;
      end else if (next_ready) begin
         this_valid <= 1'b0;
      end
   end

`ifdef FORMAL
   a_onehot: assert property (@(posedge clk) $onehot0(this_ready));
   a_stall:  assert property (@(posedge clk) disable iff (!reset)
                (this_valid && !next_ready) |=>
                (this_valid && $stable(output_num) && $stable(output_tag)));
   a_rst:    assert property (@(posedge clk) $rose(reset) |-> !this_valid);
`endif

endmodule
